rom_uart_loader: RTL and testbench
==================================

# rom_uart_loader

Synthesizable program loader that writes the instruction ROM over its dual-port RAM write port from a UART byte stream. It holds the RISC-V core in reset while loading and releases it once a checksummed image is written. It replaces the simulation-only `$readmemh` ROM preload on hardware and sits in `riscv_soc` between the board UART RX pin and the ROM write port and core reset.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000, clock frequency in Hz.
- `BAUD`, 115200, UART bit rate.
- `ADDR_W`, 12, ROM byte-address width. Capacity is 2^ADDR_W/4 words.

Ports:
- `clk`  input  1  system clock.
- `rstn`  input  1  reset, asynchronous, active-low.
- `uart_rx`  input  1  asynchronous serial input, idles high.
- `rom_we`  output  1  ROM write strobe, one cycle per word.
- `rom_waddr`  output  ADDR_W  ROM byte address, word aligned (low 2 bits are 0).
- `rom_wdata`  output  32  ROM write data.
- `core_rstn`  output  1  active-low reset to the core.
- `load_done`  output  1  last load succeeded; core is running.
- `load_err`  output  1  last load failed; sticky until the next sync byte.

## Operation
Frame format, 8N1, LSB first:
- Sync byte 0xA5.
- Word count N, 4 bytes, little-endian.
- N data words, each 4 bytes little-endian.
- Checksum byte: sum of all data bytes mod 256. Count bytes are excluded.

FSM states: IDLE, CNT, DATA, CSUM, RUN, ERROR.
- IDLE: wait for byte 0xA5; other bytes are ignored. On sync: go to CNT, clear the byte and word counters, clear `load_err` and `load_done`, set `core_rstn`=0.
- CNT: assemble N after 4 bytes.
  - N > 2^ADDR_W/4 → ERROR.
  - N = 0 → CSUM.
  - Otherwise → DATA.
- DATA: assemble each word from 4 bytes and add every byte to an 8-bit checksum accumulator. After byte 4, pulse `rom_we` with `rom_waddr` = word_idx*4, then increment word_idx. After word N → CSUM.
- CSUM:
  - Received byte equals the accumulator → RUN, `load_done`=1, `core_rstn`=1.
  - Mismatch → ERROR.
- RUN: core executes. A received 0xA5 restarts the load exactly as from IDLE, including reasserting core reset. Other bytes are ignored.
- ERROR: `load_err`=1, `core_rstn` stays 0. A received 0xA5 restarts the load.
- Framing error (stop bit sampled low) in CNT, DATA or CSUM: the byte is discarded and the FSM goes to ERROR. In IDLE, RUN or ERROR a framing error is ignored.
- Words already written before an error remain in ROM. No rollback.

UART receiver:
- 2-flop synchronizer on `uart_rx`.
- Bit period BIT = CLK_FREQ/BAUD cycles (integer division).
- Start is detected on the falling edge and re-checked low at BIT/2. Data and stop bits are sampled at BIT intervals from that point.
- False start (high at BIT/2): return to line idle; no byte is produced.
- Output: `rx_valid` pulses 1 cycle with `rx_data` and `rx_ferr`.

## Timing
- Reset values: `rom_we`=0, `rom_waddr`=0, `rom_wdata`=0, `core_rstn`=0, `load_done`=0, `load_err`=0. FSM in IDLE, UART RX idle.
- `rx_valid` fires 1 cycle after the stop-bit sample. Measured from the `uart_rx` falling edge: about 9.5*BIT + 3 cycles, including the synchronizer.
- `rom_we` is registered and asserts on the cycle after the `rx_valid` of a word's 4th byte. `rom_waddr` and `rom_wdata` are valid in the same cycle. `rom_waddr`/`rom_wdata` are held after the strobe; `rom_we` is never high for 2 consecutive cycles.
- `core_rstn` and `load_done` go high on the cycle after the checksum byte's `rx_valid`.
- `core_rstn` goes low on the cycle after a sync byte's `rx_valid` in RUN or ERROR.
- Address is computed as {word_idx, 2'b00} truncated to ADDR_W. N = capacity exactly is legal and the last address is 2^ADDR_W-4.
- The checksum accumulator wraps mod 256.
- `rstn` asserted mid-load: all state returns to reset values immediately. A partially written ROM is not cleared.

## Structure
- Package `loader_pkg` holds:
  - the state enum `loader_state_t`;
  - `SYNC_BYTE` = 8'hA5;
  - the function computing BIT from CLK_FREQ and BAUD.
- Sub-module `uart_rx`, parameterised by CLK_FREQ and BAUD. Its outputs are `rx_valid`, `rx_data[7:0]` and `rx_ferr`.
- The frame FSM, assembly shift register and counters live in `rom_uart_loader`.

## Test plan
Benches run with CLK_FREQ=50_000_000 and BAUD=5_000_000, so BIT=10.
- Good load: send A5, 02 00 00 00, then words 0x00100093 and 0x00000013, then checksum 0xB6 → `rom_we` pulses twice, at addr 0 with data 0x00100093 and at addr 4 with data 0x00000013; `load_done`=1 and `core_rstn`=1 one cycle after the checksum byte.
- Bad checksum: same frame with checksum 0xB7 → both words written, `load_err`=1, `core_rstn` stays 0. Resending the good frame then gives `load_done`=1 and `load_err`=0.
- Oversize and empty: with ADDR_W=4 (4 words), N=5 → ERROR right after the 4th count byte and no `rom_we`. N=0 followed by checksum 00 → RUN.
- Framing error: stop bit driven low on the 2nd data byte → ERROR, no `rom_we`. A glitch low for 3 cycles on an idle line → no byte produced.
- Reload and reset: after a good load, send A5 → `core_rstn`=0 on the next cycle. Assert `rstn` during DATA → all outputs return to reset values and the FSM is back in IDLE.
- Noise in IDLE: bytes 00, FF, 5A before A5 → ignored; the subsequent frame loads correctly.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and helpers for the UART program loader.
package loader_pkg;

  // Frame-level loader states.
  typedef enum logic [2:0] {
    IDLE,
    CNT,
    DATA,
    CSUM,
    RUN,
    ERROR
  } loader_state_t;

  // Byte-level receiver states.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Clock cycles per UART bit (integer division).
  function automatic int bit_cycles(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/rom_uart_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, start re-check at half bit,
// then one sample per bit period; emits a 1-cycle rx_valid with data and
// a framing-error flag (stop bit sampled low).
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ferr,
  output rx_state_t  dbg_state
);

  localparam int BIT  = bit_cycles(CLK_FREQ, BAUD);
  localparam int HALF = BIT / 2;

  rx_state_t   state_q, state_d;
  logic        sync1_q, sync2_q, prev_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;

  // Synchronizer, edge-history flop and FSM registers; line idles high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Bit timing and sampling decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = ferr_q;
    unique case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == 16'(HALF - 1)) begin
          cnt_d = '0;
          bit_d = '0;
          // A line back high by mid-start was a glitch, not a byte.
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (cnt_q == 16'(BIT - 1)) begin
          cnt_d  = '0;
          data_d = {sync2_q, data_q[7:1]};
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q == 16'(BIT - 1)) begin
          cnt_d   = '0;
          valid_d = 1'b1;
          ferr_d  = !sync2_q;
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_valid  = valid_q;
  assign rx_data   = data_q;
  assign rx_ferr   = ferr_q;
  assign dbg_state = state_q;

endmodule

// File: rtl/rom_uart_loader.sv
// Loads the instruction ROM from a UART frame (sync, count, words,
// checksum) and holds the core in reset until a good image is written.
// rom_we is a one-cycle strobe; address/data are held after it.
module rom_uart_loader
  import loader_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              uart_rx,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [31:0]       rom_wdata,
  output logic              core_rstn,
  output logic              load_done,
  output logic              load_err,
  output loader_state_t     dbg_state,
  output rx_state_t         dbg_rx_state
);

  localparam int CAP = 2 ** (ADDR_W - 2);  // capacity in words
  localparam int WI  = ADDR_W - 1;         // word index width, holds CAP

  logic       rx_valid, rx_ferr;
  logic [7:0] rx_data;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .clk       (clk),
    .rstn      (rstn),
    .rx        (uart_rx),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ferr   (rx_ferr),
    .dbg_state (dbg_rx_state)
  );

  loader_state_t     state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [WI-1:0]     word_idx_q, word_idx_d;
  logic [WI-1:0]     count_q, count_d;
  logic [31:0]       shift_q, shift_d;
  logic [7:0]        csum_q, csum_d;
  logic              rom_we_q, rom_we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              core_rstn_q, core_rstn_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [31:0]   assembled;
  logic [WI+1:0] addr_full;
  logic [WI-1:0] word_next;
  logic          is_sync;

  assign assembled = {rx_data, shift_q[31:8]};  // little-endian assembly
  assign addr_full = {word_idx_q, 2'b00};
  assign word_next = word_idx_q + WI'(1);
  assign is_sync   = rx_valid && !rx_ferr && (rx_data == SYNC_BYTE);

  // Frame FSM and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      word_idx_q  <= '0;
      count_q     <= '0;
      shift_q     <= '0;
      csum_q      <= '0;
      rom_we_q    <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      core_rstn_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      word_idx_q  <= word_idx_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      csum_q      <= csum_d;
      rom_we_q    <= rom_we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      core_rstn_q <= core_rstn_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Next-state: byte-driven frame parsing, ROM strobe and status flags.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    word_idx_d  = word_idx_q;
    count_d     = count_q;
    shift_d     = shift_q;
    csum_d      = csum_q;
    rom_we_d    = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    core_rstn_d = core_rstn_q;
    done_d      = done_q;
    err_d       = err_q;
    unique case (state_q)
      IDLE, RUN, ERROR: begin
        // Framing errors and non-sync bytes are ignored here.
        if (is_sync) begin
          state_d     = CNT;
          byte_cnt_d  = '0;
          word_idx_d  = '0;
          csum_d      = '0;
          err_d       = 1'b0;
          done_d      = 1'b0;
          core_rstn_d = 1'b0;
        end
      end
      CNT: begin
        if (rx_valid) begin
          if (rx_ferr) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else begin
            shift_d    = assembled;
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              count_d = assembled[WI-1:0];
              if (assembled > 32'(CAP)) begin
                state_d = ERROR;
                err_d   = 1'b1;
              end else if (assembled == 32'd0) begin
                state_d = CSUM;
              end else begin
                state_d = DATA;
              end
            end
          end
        end
      end
      DATA: begin
        if (rx_valid) begin
          if (rx_ferr) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else begin
            shift_d    = assembled;
            csum_d     = csum_q + rx_data;
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              rom_we_d   = 1'b1;
              waddr_d    = addr_full[ADDR_W-1:0];
              wdata_d    = assembled;
              word_idx_d = word_next;
              if (word_next == count_q) state_d = CSUM;
            end
          end
        end
      end
      CSUM: begin
        if (rx_valid) begin
          if (rx_ferr || (rx_data != csum_q)) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else begin
            state_d     = RUN;
            done_d      = 1'b1;
            core_rstn_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rom_we    = rom_we_q;
  assign rom_waddr = waddr_q;
  assign rom_wdata = wdata_q;
  assign core_rstn = core_rstn_q;
  assign load_done = done_q;
  assign load_err  = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rom_uart_loader.sv
// Bench for rom_uart_loader: BIT=10, 4-word ROM (ADDR_W=4).
module tb_rom_uart_loader;
  import loader_pkg::*;

  localparam int ADDR_W = 4;
  localparam int CAP    = 4;
  localparam int BIT    = 10;
  localparam int EW     = ADDR_W + 32;

  logic              clk;
  logic              rstn;
  logic              uart;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_waddr;
  logic [31:0]       rom_wdata;
  logic              core_rstn;
  logic              load_done;
  logic              load_err;
  loader_state_t     dbg_state;
  rx_state_t         dbg_rx_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_q[$];
  logic          we_prev = 1'b0;

  rom_uart_loader #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .uart_rx      (uart),
    .rom_we       (rom_we),
    .rom_waddr    (rom_waddr),
    .rom_wdata    (rom_wdata),
    .core_rstn    (core_rstn),
    .load_done    (load_done),
    .load_err     (load_err),
    .dbg_state    (dbg_state),
    .dbg_rx_state (dbg_rx_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ROM write monitor: capture writes, strobe must never be 2 cycles long
  always @(negedge clk) begin
    if (rom_we) begin
      got_q.push_back({rom_waddr, rom_wdata});
      check("we_single_cycle", 64'(we_prev), 64'd0);
    end
    we_prev = rom_we;
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart = b[i];
      repeat (BIT) @(negedge clk);
    end
    uart = stop;
    repeat (BIT) @(negedge clk);
    uart = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic glitch();
    @(negedge clk);
    uart = 1'b0;
    repeat (3) @(negedge clk);
    uart = 1'b1;
    repeat (2 * BIT) @(negedge clk);
  endtask

  // Full frame; the reference model decides which words land in ROM.
  task automatic send_frame(input int n, input logic [31:0] w [4], input int delta);
    logic [7:0]  sum;
    logic [31:0] nn;
    sum = 8'd0;
    nn  = 32'(n);
    send_byte(SYNC_BYTE, 1'b1);
    send_word(nn);
    if (n <= CAP) begin
      for (int k = 0; k < n; k++) begin
        send_word(w[k]);
        sum = sum + w[k][7:0] + w[k][15:8] + w[k][23:16] + w[k][31:24];
        exp_q.push_back({ADDR_W'(k * 4), w[k]});
      end
      check("done_before_csum", 64'(load_done), 64'd0);
      send_byte(sum + 8'(delta), 1'b1);
    end
  endtask

  // scoreboard drain
  task automatic check_sb(input string tag);
    check({tag, "_wr_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_wr"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_status(input string tag, input logic done, input logic err);
    check({tag, "_done"}, 64'(load_done), 64'(done));
    check({tag, "_err"}, 64'(load_err), 64'(err));
    check({tag, "_core_rstn"}, 64'(core_rstn), 64'(done));
    check({tag, "_state"}, 64'(dbg_state), done ? 64'(RUN) : 64'(ERROR));
  endtask

  typedef struct {
    int          n;
    logic [31:0] w [4];
    int          delta;
    logic        exp_done;
    logic        exp_err;
    int          exp_nwr;
  } vec_t;

  vec_t          vecs [6];
  logic [31:0]   spec_w [4];
  logic [31:0]   rw [4];

  initial begin
    vecs[0] = '{1, '{32'hDEADBEEF, 0, 0, 0}, 0, 1'b1, 1'b0, 1};
    vecs[1] = '{4, '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00}, 0, 1'b1, 1'b0, 4};
    vecs[2] = '{3, '{32'h01020304, 32'hA0B0C0D0, 32'h0F0F0F0F, 0}, 1, 1'b0, 1'b1, 3};
    vecs[3] = '{0, '{0, 0, 0, 0}, 0, 1'b1, 1'b0, 0};
    vecs[4] = '{5, '{0, 0, 0, 0}, 0, 1'b0, 1'b1, 0};
    vecs[5] = '{2, '{32'hFFFFFFFF, 32'hFEFEFEFE, 0, 0}, 0, 1'b1, 1'b0, 2};
    spec_w  = '{32'h00100093, 32'h00000013, 0, 0};

    uart = 1'b1;
    rstn = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_we", 64'(rom_we), 64'd0);
    check("rst_waddr", 64'(rom_waddr), 64'd0);
    check("rst_wdata", 64'(rom_wdata), 64'd0);
    check("rst_core_rstn", 64'(core_rstn), 64'd0);
    check("rst_done", 64'(load_done), 64'd0);
    check("rst_err", 64'(load_err), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check("rst_rx_state", 64'(dbg_rx_state), 64'(RX_IDLE));
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // Good load, literal bytes and checksum B6
    send_byte(8'hA5, 1'b1);
    send_word(32'd2);
    send_word(32'h00100093);
    send_word(32'h00000013);
    exp_q.push_back({4'h0, 32'h00100093});
    exp_q.push_back({4'h4, 32'h00000013});
    check("good_core_rstn_before", 64'(core_rstn), 64'd0);
    send_byte(8'hB6, 1'b1);
    check_status("good", 1'b1, 1'b0);
    check_sb("good");

    // Bad checksum B7: words still written, error sticky
    send_byte(8'hA5, 1'b1);
    send_word(32'd2);
    send_word(32'h00100093);
    send_word(32'h00000013);
    exp_q.push_back({4'h0, 32'h00100093});
    exp_q.push_back({4'h4, 32'h00000013});
    send_byte(8'hB7, 1'b1);
    check_status("badcs", 1'b0, 1'b1);
    check_sb("badcs");
    send_frame(2, spec_w, 0);
    check_status("resend", 1'b1, 1'b0);
    check_sb("resend");

    // Reload from RUN reasserts core reset; a short glitch yields no byte
    send_byte(8'hA5, 1'b1);
    check("reload_core_rstn", 64'(core_rstn), 64'd0);
    check("reload_done", 64'(load_done), 64'd0);
    check("reload_state", 64'(dbg_state), 64'(CNT));
    glitch();
    check("glitch_rx_idle", 64'(dbg_rx_state), 64'(RX_IDLE));
    send_word(32'd1);
    send_word(32'hCAFEF00D);
    exp_q.push_back({4'h0, 32'hCAFEF00D});
    send_byte(8'hC5, 1'b1);
    check_status("glitch", 1'b1, 1'b0);
    check_sb("glitch");

    // Framing error on the 2nd data byte
    send_byte(8'hA5, 1'b1);
    send_word(32'd2);
    send_byte(8'h93, 1'b1);
    send_byte(8'h00, 1'b0);
    check_status("ferr", 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check_sb("ferr");

    // Noise in IDLE-like states is ignored
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    check("noise_err_kept", 64'(load_err), 64'd1);
    send_frame(2, spec_w, 0);
    check_status("noise", 1'b1, 1'b0);
    check_sb("noise");

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].n, vecs[v].w, vecs[v].delta);
      check($sformatf("vec%0d_nwr", v), 64'(exp_q.size()), 64'(vecs[v].exp_nwr));
      check_status($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err);
      check_sb($sformatf("vec%0d", v));
    end

    // Randomised frames against the frame-level model
    for (int r = 0; r < 6; r++) begin
      int   n, delta;
      logic ok;
      n = $urandom_range(0, 5);
      for (int k = 0; k < 4; k++) rw[k] = $urandom;
      delta = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 255) : 0;
      ok = (n <= CAP) && (delta == 0);
      send_frame(n, rw, delta);
      check_status($sformatf("rnd%0d", r), ok, !ok);
      check_sb($sformatf("rnd%0d", r));
    end

    // Reset asserted in the middle of DATA
    send_frame(1, vecs[0].w, 0);
    check_sb("pre_rst");
    send_byte(8'hA5, 1'b1);
    send_word(32'd1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    check("mid_state", 64'(dbg_state), 64'(DATA));
    rstn = 1'b0;
    #2;
    check("mrst_waddr", 64'(rom_waddr), 64'd0);
    check("mrst_wdata", 64'(rom_wdata), 64'd0);
    check("mrst_core_rstn", 64'(core_rstn), 64'd0);
    check("mrst_done", 64'(load_done), 64'd0);
    check("mrst_err", 64'(load_err), 64'd0);
    check("mrst_state", 64'(dbg_state), 64'(IDLE));
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check_sb("mrst");
    send_frame(4, vecs[1].w, 0);
    check_status("post_rst", 1'b1, 1'b0);
    check_sb("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
